// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver: synchroniser, glitch filter, frame checker, FWFT byte FIFO
// Optional prefix decode via PS2_PREFIX_DECODE_EN (E0/F0 folded into ext/rel flags).
module ps2_rx_fifo #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    code_data,
    output logic                          code_ext,
    output logic                          code_rel,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [7:0]                    err_count,
    input  logic                          clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
`ifdef PS2_PREFIX_DECODE_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic                   filt_q, filt_d;
    logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          entry;
    logic                   sync_clk, sync_dat, fe, push, pop, push_ok, full;
`ifdef PS2_PREFIX_DECODE_EN
    logic                   ext_q, ext_d, rel_q, rel_d;
`endif

    // Front end: synchronise both pins, then require FILT_LEN agreeing samples before the clock moves
    always_comb begin
        sync_clk   = clk_sync_q[SYNC_STAGES-1];
        sync_dat   = dat_sync_q[SYNC_STAGES-1];
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        filt_d     = filt_q;
        flt_cnt_d  = '0;
        fe         = 1'b0;
        if (sync_clk != filt_q) begin
            if (flt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = sync_clk;
                fe     = filt_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push         = 1'b0;
        to_cnt_d     = (state_q == S_IDLE || fe) ? '0 : to_cnt_q + 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
        ext_d        = ext_q;
        rel_d        = rel_q;
        entry        = {ext_q, rel_q, shift_q};
`else
        entry        = shift_q;
`endif
        if (fe) begin
            case (state_q)
                S_IDLE: begin
                    if (!sync_dat) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {sync_dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = sync_dat;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (^{shift_q, par_q} == 1'b0) begin
                        parity_err_d = 1'b1;
                    end else if (!sync_dat) begin
                        frame_err_d = 1'b1;
                    end else begin
`ifdef PS2_PREFIX_DECODE_EN
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_d = 1'b1;
                        end else begin
                            push  = 1'b1;
                            ext_d = 1'b0;
                            rel_d = 1'b0;
                        end
`else
                        push = 1'b1;
`endif
                    end
                end
            endcase
        end else if (state_q != S_IDLE && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end
`ifdef PS2_PREFIX_DECODE_EN
        if (parity_err_d || frame_err_d) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end
`endif
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle
    always_comb begin
        full       = (count_q == FULL_CNT);
        pop        = (count_q != '0) && code_ready;
        push_ok    = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
        err_cnt_d  = err_cnt_q;
        if (clr_err) err_cnt_d = '0;
        else if ((parity_err_d || frame_err_d || overflow_d) && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            filt_q       <= 1'b1;
            flt_cnt_q    <= '0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            err_cnt_q    <= '0;
`ifdef PS2_PREFIX_DECODE_EN
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
`endif
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            filt_q       <= filt_d;
            flt_cnt_q    <= flt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            err_cnt_q    <= err_cnt_d;
`ifdef PS2_PREFIX_DECODE_EN
            ext_q        <= ext_d;
            rel_q        <= rel_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry;
    end

    assign code_valid = (count_q != '0);
    assign code_data  = code_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
`ifdef PS2_PREFIX_DECODE_EN
    assign code_ext   = code_valid & mem_q[rd_ptr_q][9];
    assign code_rel   = code_valid & mem_q[rd_ptr_q][8];
`else
    assign code_ext   = 1'b0;
    assign code_rel   = 1'b0;
`endif
    assign fifo_count = count_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign err_count  = err_cnt_q;
endmodule
